iterative_shifter: RTL and testbench

- Multi-cycle, parametrised shift unit for the ALU datapath and its successor to the single-cycle left shifter.
- Supports logical left, logical right, arithmetic right and rotate-left.
- Resolves one shift-amount bit per clock, from LSB to MSB, with a shift of 2^k at stage k.
- Uses valid/ready handshakes on both sides so the controller can stall it.

---
 rtl/iterative_shifter.sv | 125 ++++++++++++
 tb/tb_iterative_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL unit resolving one shamt bit per cycle (LSB first); latency L cycles.
// Backpressure: the result is held in DONE until out_ready; in_ready is asserted only in IDLE.
module iterative_shifter #(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [L-1:0] shamt,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0]   OP_SLL = 2'b00;
  localparam logic [1:0]   OP_SRL = 2'b01;
  localparam logic [1:0]   OP_SRA = 2'b11;
  localparam logic [L-1:0] K_LAST = L'(L - 1);

  state_e       state_q, state_d;
  logic [N-1:0] w_q, w_d;
  logic [L-1:0] k_q, k_d;
  logic [L-1:0] shamt_q, shamt_d;
  logic [1:0]   op_q, op_d;
  logic         sign_q, sign_d;

  // Stage j applies a fixed shift of 2^j; the stage counter picks one per cycle.
  logic [N-1:0] stage_res [L];

  for (genvar j = 0; j < L; j++) begin : g_stage
    localparam int S = 1 << j;
    assign stage_res[j] =
        (op_q == OP_SLL) ? {w_q[N-1-S:0], {S{1'b0}}} :
        (op_q == OP_SRL) ? {{S{1'b0}}, w_q[N-1:S]} :
        (op_q == OP_SRA) ? {{S{sign_q}}, w_q[N-1:S]} :
                           {w_q[N-1-S:0], w_q[N-1:N-S]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SHIFT;
      S_SHIFT: if (k_q == K_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_d     = w_q;
    k_d     = k_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          w_d     = in;
          shamt_d = shamt;
          op_d    = op;
          sign_d  = in[N-1];
          k_d     = '0;
        end
      end
      S_SHIFT: begin
        if (shamt_q[k_q]) w_d = stage_res[k_q];
        k_d = k_q + L'(1);
      end
      default: w_d = w_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      k_q     <= '0;
      shamt_q <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
    end else begin
      w_q     <= w_d;
      k_q     <= k_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  assign out = w_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// Scoreboarded bench for iterative_shifter: directed corner cases, backpressure, mid-op reset, random regression.
module tb_iterative_shifter;
  localparam int N = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic [L-1:0] shamt;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dout;
  logic         busy;

  iterative_shifter #(.N(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .shamt     (shamt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int fails = 0;
  int cyc = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    chk++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: whole-amount shifts on the full operand.
  function automatic logic [N-1:0] ref_model(input logic [N-1:0] a, input int s, input logic [1:0] o);
    logic [2*N-1:0] dbl;
    case (o)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b11:   return N'($signed(a) >>> s);
      default: begin
        dbl = {a, a} << s;
        return dbl[2*N-1:N];
      end
    endcase
  endfunction

  // Drives one cycle just after the rising edge; a request seen with in_ready is accepted at the next edge.
  task automatic drive(input logic iv, input logic [N-1:0] d, input logic [L-1:0] s,
                       input logic [1:0] o, input logic ordy,
                       input logic use_x, input logic [N-1:0] xv);
    @(posedge clk);
    #1;
    in_valid  = iv;
    din       = d;
    shamt     = s;
    op        = o;
    out_ready = ordy;
    if (iv && in_ready && rst_n) begin
      exp_q.push_back(use_x ? xv : ref_model(d, int'(s), o));
      exp_cyc_q.push_back(cyc + 1 + L);
      n_pushed++;
    end
  endtask

  task automatic idle_cycle(input logic ordy);
    drive(1'b0, $urandom, L'($urandom), 2'($urandom), ordy, 1'b0, '0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
      idle_cycle(1'b1);
      n++;
    end
    chk++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain: timed out with %0d results outstanding", exp_q.size());
    end
  endtask

  task automatic req(input logic [N-1:0] d, input logic [L-1:0] s, input logic [1:0] o, input logic [N-1:0] xv);
    drive(1'b1, d, s, o, 1'b1, 1'b1, xv);
    drain(40);
  endtask

  // Monitor: latency on each rising out_valid, data on each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_cyc_q.size() == 0) begin
          chk++;
          fails++;
          $display("FAIL unexpected_valid: out_valid rose with no request outstanding (t=%0t)", $time);
        end else begin
          check("latency", N'(cyc), N'(exp_cyc_q[0]));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk++;
          fails++;
          $display("FAIL spurious_result: got 0x%08h with empty scoreboard", dout);
        end else begin
          check("result", dout, exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
          n_popped++;
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] bp_exp;
    logic         saw;
    int           n;

    rst_n = 1'b0; in_valid = 1'b0; din = '0; shamt = '0; op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out", dout, '0);
    check("rst_out_valid", N'(out_valid), '0);
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_busy", N'(busy), '0);

    req(32'h0000_00FF, 5'd4,  2'b00, 32'h0000_0FF0);
    req(32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000);
    req(32'h8000_0010, 5'd4,  2'b01, 32'h0800_0001);
    req(32'h8000_0010, 5'd4,  2'b11, 32'hF800_0001);
    req(32'h8000_0010, 5'd31, 2'b11, 32'hFFFF_FFFF);
    req(32'h8000_0001, 5'd1,  2'b10, 32'h0000_0003);
    req(32'h8000_0001, 5'd0,  2'b10, 32'h8000_0001);
    req(32'h7000_0010, 5'd4,  2'b11, 32'h0700_0001);

    // Backpressure: hold the result for 10 cycles while hammering in_valid.
    bp_exp = ref_model(32'hA5A5_0F0F, 8, 2'b10);
    drive(1'b1, 32'hA5A5_0F0F, 5'd8, 2'b10, 1'b0, 1'b0, '0);
    n = 0;
    while (!out_valid && n < 20) begin
      idle_cycle(1'b0);
      n++;
    end
    check("bp_reached_done", N'(out_valid), N'(1));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, L'($urandom), 2'($urandom), 1'b0, 1'b0, '0);
      check("bp_out_stable", dout, bp_exp);
      check("bp_valid_held", N'(out_valid), N'(1));
      check("bp_in_ready_low", N'(in_ready), '0);
      check("bp_busy", N'(busy), N'(1));
    end
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    check("bp_back_to_idle", N'(in_ready), N'(1));
    drain(40);

    // Asynchronous reset in the middle of SHIFT abandons the request.
    drive(1'b1, 32'h1234_5678, 5'd7, 2'b00, 1'b1, 1'b0, '0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", N'(in_ready), N'(1));
    check("arst_busy", N'(busy), '0);
    check("arst_out", dout, '0);
    exp_q.delete();
    exp_cyc_q.delete();
    n_pushed--;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (L + 3) begin
      idle_cycle(1'b1);
      if (out_valid) saw = 1'b1;
    end
    check("arst_no_result", N'(saw), '0);

    // Random regression with random stalls on both sides.
    n = 0;
    while (n_pushed < 1000 + 9 && n < 30000) begin
      logic [L-1:0] s;
      s = L'($urandom);
      if ($urandom_range(0, 7) == 0) s = '0;
      else if ($urandom_range(0, 7) == 0) s = L'(N - 1);
      drive($urandom_range(0, 9) < 7, $urandom, s, 2'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
      n++;
    end
    drain(100);
    check("no_loss_or_dup", N'(n_popped), N'(n_pushed));

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end

endmodule
